// File: rtl/prog_pkg.sv
// Shared types and default constants for the Start/Ack run launcher.
package prog_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      ARM   = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_TIMEOUT = 2'd1,
      ST_STUCK   = 2'd2,
      ST_ABORT   = 2'd3
   } status_t;

   localparam int          DEF_START_LEN = 2;
   localparam int          DEF_CNT_W     = 16;
   localparam int unsigned DEF_TIMEOUT   = 32'h0000_FFF0;
   localparam int          DEF_ARM_LIM   = 4;

   // START length counter is 4 bits wide, enough for START_LEN up to 15.
   function automatic logic [3:0] lenLast(input int len);
      return 4'(len - 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, plus a compare against a fixed limit.
module sat_counter #(
   parameter int          W     = 16,
   parameter int unsigned LIMIT = 0
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Clear,
   input  logic         Enable,
   output logic [W-1:0] Count,
   output logic [W-1:0] CountInc,
   output logic         AtLimit
);

   localparam logic [W-1:0] MAX_VAL = '1;
   localparam logic [W-1:0] LIM     = W'(LIMIT);

   logic atMax;

   assign atMax    = (Count == MAX_VAL);
   // CountInc is the value the counter would take this cycle; it never wraps.
   assign CountInc = atMax ? Count : Count + 1'b1;
   assign AtLimit  = (Count == LIM);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Count <= '0;
      end else if (Clear) begin
         Count <= '0;
      end else if (Enable) begin
         Count <= CountInc;
      end
   end

endmodule

// File: rtl/prog_launcher.sv
// Host-side initiator of the Start/Ack run protocol: pulses Start, times the run
// until Ack, flags hung/stuck runs and returns one status/cycle-count response per run.
module prog_launcher
   import prog_pkg::*;
#(
   parameter int          START_LEN = DEF_START_LEN,
   parameter int          CNT_W     = DEF_CNT_W,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
   parameter int          ARM_LIM   = DEF_ARM_LIM
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  logic             Abort,
   output logic             Start,
   input  logic             Ack,
   output logic             RespValid,
   input  logic             RespReady,
   output logic [CNT_W-1:0] RespCycles,
   output logic [1:0]       RespStatus,
   output logic             Busy,
   output logic [7:0]       RunCount,
   output state_t           DbgState
);

   // Handshakes: a request transfers on a cycle where ReqValid && ReqReady; a
   // response transfers on a cycle where RespValid && RespReady. Neither side may
   // withdraw valid before the transfer, and the response payload holds until then.

   localparam logic [3:0]       START_LAST = lenLast(START_LEN);
   localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_LIM - 1);

   state_t           state;
   logic [3:0]       lenCnt;
   logic [CNT_W-1:0] cycCount;
   logic [CNT_W-1:0] cycInc;
   logic             cycAtLimit;
   logic             cntClear;
   logic             cntEnable;
   logic             abortHit;

   assign ReqReady = (state == IDLE);
   assign Busy     = (state != IDLE);
   assign DbgState = state;

   assign abortHit  = Abort && ((state == START) || (state == ARM) || (state == RUN));
   assign cntClear  = ((state == IDLE) && ReqValid) ||
                      ((state == START) && !Abort && (lenCnt == START_LAST));
   assign cntEnable = (state == ARM) || (state == RUN);

   sat_counter #(
      .W     (CNT_W),
      .LIMIT (TIMEOUT)
   ) u_cycCounter (
      .Clk      (Clk),
      .Reset    (Reset),
      .Clear    (cntClear),
      .Enable   (cntEnable),
      .Count    (cycCount),
      .CountInc (cycInc),
      .AtLimit  (cycAtLimit)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         Start      <= 1'b0;
         RespValid  <= 1'b0;
         RespCycles <= '0;
         RespStatus <= ST_OK;
         RunCount   <= '0;
         lenCnt     <= '0;
      end else if (abortHit) begin
         // Abort outranks every other transition; the count reported is what was
         // accumulated before the abort cycle.
         state      <= DONE;
         Start      <= 1'b0;
         RespValid  <= 1'b1;
         RespStatus <= ST_ABORT;
         RespCycles <= cycCount;
      end else begin
         case (state)
            IDLE: begin
               if (ReqValid) begin
                  state  <= START;
                  Start  <= 1'b1;
                  lenCnt <= '0;
               end
            end
            START: begin
               if (lenCnt == START_LAST) begin
                  state <= ARM;
                  Start <= 1'b0;
               end else begin
                  lenCnt <= lenCnt + 4'd1;
               end
            end
            ARM: begin
               if (!Ack) begin
                  state <= RUN;
               end else if (cycCount == ARM_LAST) begin
                  state      <= DONE;
                  RespValid  <= 1'b1;
                  RespStatus <= ST_STUCK;
                  RespCycles <= cycInc;
               end
            end
            RUN: begin
               // Ack is tested before the limit so a simultaneous finish reports OK.
               if (Ack) begin
                  state      <= DONE;
                  RespValid  <= 1'b1;
                  RespStatus <= ST_OK;
                  RespCycles <= cycInc;
               end else if (cycAtLimit) begin
                  state      <= DONE;
                  RespValid  <= 1'b1;
                  RespStatus <= ST_TIMEOUT;
                  RespCycles <= cycInc;
               end
            end
            DONE: begin
               if (RespReady) begin
                  state     <= IDLE;
                  RespValid <= 1'b0;
                  RunCount  <= RunCount + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               Start <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_launcher.sv
// Directed and randomized runs of prog_launcher against a run-outcome model
// computed from the protocol timing rules.
module tb_prog_launcher;
   import prog_pkg::*;

   localparam int START_LEN = 2;
   localparam int CNT_W     = 16;
   localparam int TIMEOUT   = 100;
   localparam int ARM_LIM   = 4;

   logic             Clk;
   logic             Reset;
   logic             ReqValid;
   logic             ReqReady;
   logic             Abort;
   logic             Start;
   logic             Ack;
   logic             RespValid;
   logic             RespReady;
   logic [CNT_W-1:0] RespCycles;
   logic [1:0]       RespStatus;
   logic             Busy;
   logic [7:0]       RunCount;
   state_t           dbgState;

   int checks   = 0;
   int failures = 0;
   int expRun   = 0;
   logic [17:0] exp_q[$];

   prog_launcher #(
      .START_LEN (START_LEN),
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT),
      .ARM_LIM   (ARM_LIM)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .ReqValid   (ReqValid),
      .ReqReady   (ReqReady),
      .Abort      (Abort),
      .Start      (Start),
      .Ack        (Ack),
      .RespValid  (RespValid),
      .RespReady  (RespReady),
      .RespCycles (RespCycles),
      .RespStatus (RespStatus),
      .Busy       (Busy),
      .RunCount   (RunCount),
      .DbgState   (dbgState)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Ack seen by the launcher t cycles after acceptance: high through START,
   // high for h ARM cycles, low for one ARM cycle plus r RUN cycles, then high.
   function automatic logic ackAt(input int t, input int h, input int r);
      int k;
      k = t - START_LEN;
      if (k <= 0) return 1'b1;
      if (k <= h) return 1'b1;
      if (k <= h + 1 + r) return 1'b0;
      return 1'b1;
   endfunction

   // Entered just after a rising edge with the DUT idle; leaves it idle again.
   // a = acceptance-relative cycle carrying Abort (0 = no abort).
   task automatic run_one(input int h, input int r, input int a, input int stall);
      int tEnd, doneT, expCycles, jEnd;
      logic [1:0] expStatus;
      logic [17:0] expResp;
      bit aborted;
      if (h >= ARM_LIM) begin
         tEnd      = START_LEN + ARM_LIM;
         expCycles = ARM_LIM;
         expStatus = ST_STUCK;
      end else begin
         jEnd      = (r + 1 < TIMEOUT - h) ? r + 1 : TIMEOUT - h;
         tEnd      = START_LEN + h + 1 + jEnd;
         expCycles = h + 1 + jEnd;
         expStatus = (r + 1 <= TIMEOUT - h) ? ST_OK : ST_TIMEOUT;
      end
      aborted = (a >= 1) && (a <= tEnd);
      if (aborted) expStatus = ST_ABORT;
      doneT = aborted ? a + 1 : tEnd + 1;
      exp_q.push_back({expStatus, 16'(expCycles)});

      for (int t = 0; t < doneT; t++) begin
         ReqValid  = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         Abort     = (t == a) && (a != 0);
         Ack       = ackAt(t, h, r);
         RespReady = 1'($urandom_range(0, 1));
         @(negedge Clk);
         check("start", {31'd0, Start}, {31'd0, (t >= 1 && t <= START_LEN)});
         check("busy", {31'd0, Busy}, {31'd0, (t != 0)});
         check("req_ready", {31'd0, ReqReady}, {31'd0, (t == 0)});
         check("resp_valid_run", {31'd0, RespValid}, 32'd0);
         check("run_count", {24'd0, RunCount}, 32'(expRun));
         @(posedge Clk);
         #1;
      end

      expResp = exp_q.pop_front();
      for (int i = 0; i <= stall; i++) begin
         ReqValid  = 1'($urandom_range(0, 1));
         Abort     = 1'($urandom_range(0, 1));
         Ack       = 1'($urandom_range(0, 1));
         RespReady = (i == stall);
         @(negedge Clk);
         check("resp_valid", {31'd0, RespValid}, 32'd1);
         check("resp_status", {30'd0, RespStatus}, {30'd0, expResp[17:16]});
         if (expResp[17:16] != ST_ABORT)
            check("resp_cycles", {16'd0, RespCycles}, {16'd0, expResp[15:0]});
         check("start_done", {31'd0, Start}, 32'd0);
         check("req_ready_done", {31'd0, ReqReady}, 32'd0);
         check("busy_done", {31'd0, Busy}, 32'd1);
         @(posedge Clk);
         #1;
      end
      expRun = (expRun + 1) % 256;
      Abort  = 1'b0;
   endtask

   initial begin
      int h, r, a, st;
      Reset     = 1'b0;
      ReqValid  = 1'b0;
      Abort     = 1'b0;
      Ack       = 1'b0;
      RespReady = 1'b0;
      #3;
      check("rst_start", {31'd0, Start}, 32'd0);
      check("rst_resp_valid", {31'd0, RespValid}, 32'd0);
      check("rst_resp_cycles", {16'd0, RespCycles}, 32'd0);
      check("rst_resp_status", {30'd0, RespStatus}, 32'(ST_OK));
      check("rst_run_count", {24'd0, RunCount}, 32'd0);
      check("rst_state", {29'd0, dbgState}, 32'(IDLE));
      @(posedge Clk);
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      @(negedge Clk);
      check("rst_req_ready", {31'd0, ReqReady}, 32'd1);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      @(posedge Clk);
      #1;

      run_one(0, 36, 0, 0);          // nominal run, 38 cycles
      run_one(0, 500, 0, 0);         // hung run -> timeout, 101 cycles
      run_one(ARM_LIM, 0, 0, 0);     // Ack never drops -> stuck
      run_one(0, 500, 13, 0);        // abort on RUN cycle 10
      run_one(0, 20, 0, 0);
      run_one(1, 10, 0, 5);          // response back-pressure
      run_one(0, 99, 0, 1);          // Ack on the limit cycle -> OK
      run_one(2, 97, 0, 0);
      run_one(0, 5, 1, 0);           // abort during START
      run_one(2, 5, 4, 2);           // abort during ARM

      for (int n = 0; n < 30; n++) begin
         h  = $urandom_range(0, ARM_LIM);
         r  = $urandom_range(0, 120);
         a  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0;
         st = $urandom_range(0, 3);
         run_one(h, r, a, st);
      end

      // Reset pulse in the middle of START.
      ReqValid = 1'b1;
      Ack      = 1'b1;
      @(posedge Clk);
      #1;
      ReqValid = 1'b0;
      @(negedge Clk);
      check("mid_start_high", {31'd0, Start}, 32'd1);
      #1;
      Reset = 1'b0;
      #1;
      check("async_start", {31'd0, Start}, 32'd0);
      check("async_busy", {31'd0, Busy}, 32'd0);
      check("async_resp_valid", {31'd0, RespValid}, 32'd0);
      check("async_run_count", {24'd0, RunCount}, 32'd0);
      @(posedge Clk);
      #1;
      Reset  = 1'b1;
      expRun = 0;
      exp_q.delete();
      @(negedge Clk);
      check("post_rst_req_ready", {31'd0, ReqReady}, 32'd1);
      check("post_rst_start", {31'd0, Start}, 32'd0);
      check("post_rst_resp_valid", {31'd0, RespValid}, 32'd0);
      @(posedge Clk);
      #1;
      run_one(0, 8, 0, 0);
      @(negedge Clk);
      check("final_run_count", {24'd0, RunCount}, 32'(expRun));
      check("final_req_ready", {31'd0, ReqReady}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
